pio_tx_arbiter: RTL and testbench
=================================

// Module: pio_tx_arbiter
// PURPOSE
//  Shares the single TLP packet generator / completion checker pair between NUM_REQ requesters
//  (controller FSM, debug port, future DMA sequencer). Round-robin grant, one TLP in flight at a time.
//  Allocates tags and times out lost completions. Returns per-requester done/error status.
//  Sits between requesters and the tx_*/rx_* generator/checker interface.
// PARAMETERS
//  TCQ          1     simulation clock-to-q delay on all registered assignments
//  NUM_REQ      2     requester count, 2..8
//  REQ_W        1     $clog2(NUM_REQ), minimum 1
//  CPL_TIMEOUT  1024  cycles to wait for rx_good/rx_bad after tx_done before declaring error, >=2
// PORTS
//  user_clk     in   1          single clock
//  reset        in   1          asynchronous, active-high
//  user_lnk_up  in   1          link status; low aborts and holds the block idle
//  req_valid    in   NUM_REQ    requester i has a TLP pending; held until req_ready[i]
//  req_ready    out  NUM_REQ    one-hot 1-cycle accept pulse
//  req_type     in   3*NUM_REQ  TX type code per requester (slice i = [3i+:3])
//  req_addr     in   64*NUM_REQ target address per requester
//  req_data     in   32*NUM_REQ write payload / expected read data per requester
//  rsp_valid    out  NUM_REQ    one-hot 1-cycle completion-of-transaction pulse
//  rsp_err      out  1          qualifies rsp_valid: 1 = rx_bad, timeout or link abort
//  tx_type      out  3          to generator
//  tx_tag       out  8          to generator
//  tx_addr      out  64         to generator
//  tx_data      out  32         to generator
//  tx_start     out  1          1-cycle pulse
//  tx_done      in   1          generator finished sending
//  rx_type      out  1          expected completion kind: 0 Cpl, 1 CplD
//  rx_tag       out  8          always equals tx_tag
//  rx_data      out  32         expected completion payload
//  rx_good      in   1          checker result
//  rx_bad       in   1          checker result
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, tx_tag 0, RR pointer 0, state ST_IDLE.
//  States: ST_IDLE, ST_GRANT, ST_TX_WAIT, ST_CPL_WAIT, ST_RESP.
//  ST_IDLE: if user_lnk_up and |req_valid, pick the first valid index at or after rr_ptr (wrapping),
//   latch type/addr/data/index, pulse req_ready[idx] -> ST_GRANT. rr_ptr <= idx+1, modulo NUM_REQ.
//  ST_GRANT: drive tx_type/tx_addr/tx_data/rx_data from latched values. tx_tag <= tx_tag+1 (8-bit wrap 255->0).
//   rx_type = 1 for MEMRD32/MEMRD64/IORD, else 0. tx_start pulses exactly one cycle. -> ST_TX_WAIT.
//  ST_TX_WAIT: on tx_done, posted types (MEMWR32/MEMWR64) -> ST_RESP with err=0.
//   Non-posted types (reads, IOWR) -> ST_CPL_WAIT and clear the timeout counter.
//  ST_CPL_WAIT: rx_bad -> ST_RESP, err=1. rx_good -> ST_RESP, err=0.
//   Both asserted in the same cycle: rx_bad wins. Counter reaches CPL_TIMEOUT-1 with no result -> ST_RESP, err=1.
//  ST_RESP: rsp_valid[idx] pulses 1 cycle with rsp_err -> ST_IDLE.
//  Earliest new grant is the cycle after ST_RESP; req_valid is ignored outside ST_IDLE.
//  Latency: req_valid to tx_start = 2 cycles. tx_done (posted) to rsp_valid = 2 cycles.
//  Link drop (user_lnk_up=0) in ST_GRANT/TX_WAIT/CPL_WAIT: -> ST_RESP with err=1, tx_start forced 0.
//   In ST_IDLE the block grants nothing while the link is down.
//  Undefined req_type codes (110/111): not issued; go straight to ST_RESP with err=1, tx_tag unchanged.
//  tx_*/rx_* hold their values between transactions; only tx_start and the pulses return to 0.
// STRUCTURE
//  pcie_tlp_pkg.vh: TX_TYPE_* (3-bit) and RX_TYPE_CPL/CPLD codes, shared with the generator, checker and controller.
//  Sub-module rr_arbiter: combinational first-set search from pointer plus registered pointer update. Parameter NUM_REQ.
//  Timeout counter width is $clog2(CPL_TIMEOUT).
// TESTING
//  1. Req0 MEMWR32 addr FFFF_0010 data 1234_5678:
//     tx_start 2 cycles after req_valid, tx_tag=1; tx_done -> rsp_valid=01, rsp_err=0.
//  2. Req1 MEMRD32 exp 1234_5678:
//     rx_type=1, rx_data=1234_5678, rx_tag=tx_tag; rx_good -> rsp_valid=10, err=0. Repeat with rx_bad -> err=1.
//  3. Both requesters valid continuously for 4 transactions:
//     grants alternate 0,1,0,1; tags increment 1..4.
//  4. MEMRD with no rx_good/rx_bad, CPL_TIMEOUT=16:
//     rsp_err=1 exactly 16 cycles after tx_done plus 1; next grant proceeds.
//  5. Drop user_lnk_up in ST_CPL_WAIT:
//     rsp_err=1 pulse, no tx_start while down. Assert reset mid-transaction: all outputs 0 without a clock edge.
//  6. 256 sequential writes:
//     tx_tag wraps 255 -> 0. rx_good and rx_bad together -> rsp_err=1.

Source files
------------

// File: rtl/pio_tx_arbiter_pkg.sv
// Shared TLP type codes, arbiter state encoding and type-decode helpers
// used by the PIO TX arbiter, its round-robin sub-block and the testbench.
package pio_tx_arbiter_pkg;

  // TX type codes understood by the TLP generator. Codes 3'b110 and 3'b111
  // are undefined and never forwarded to the generator.
  localparam logic [2:0] TX_TYPE_MEMRD32 = 3'b000;
  localparam logic [2:0] TX_TYPE_MEMRD64 = 3'b001;
  localparam logic [2:0] TX_TYPE_MEMWR32 = 3'b010;
  localparam logic [2:0] TX_TYPE_MEMWR64 = 3'b011;
  localparam logic [2:0] TX_TYPE_IORD    = 3'b100;
  localparam logic [2:0] TX_TYPE_IOWR    = 3'b101;

  // Completion kinds expected by the checker.
  localparam logic RX_TYPE_CPL  = 1'b0;
  localparam logic RX_TYPE_CPLD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_TX_WAIT,
    ST_CPL_WAIT,
    ST_RESP
  } arb_state_t;

  function automatic logic tx_type_defined(input logic [2:0] t);
    return (t <= TX_TYPE_IOWR);
  endfunction

  // Posted writes complete as soon as the generator has sent them.
  function automatic logic tx_type_posted(input logic [2:0] t);
    return (t == TX_TYPE_MEMWR32) || (t == TX_TYPE_MEMWR64);
  endfunction

  // Reads come back with data (CplD); IO writes get a data-less Cpl.
  function automatic logic rx_type_for(input logic [2:0] t);
    if ((t == TX_TYPE_MEMRD32) || (t == TX_TYPE_MEMRD64) || (t == TX_TYPE_IORD))
      return RX_TYPE_CPLD;
    return RX_TYPE_CPL;
  endfunction

endpackage

// File: rtl/pio_tx_arbiter_if.sv
// Requester and generator/checker signal bundle of the PIO TX arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface pio_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);

  // Requester side
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [3*NUM_REQ-1:0]  req_type;
  logic [64*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic                  rsp_err;

  // TLP generator side
  logic [2:0]            tx_type;
  logic [7:0]            tx_tag;
  logic [63:0]           tx_addr;
  logic [31:0]           tx_data;
  logic                  tx_start;
  logic                  tx_done;

  // Completion checker side
  logic                  rx_type;
  logic [7:0]            rx_tag;
  logic [31:0]           rx_data;
  logic                  rx_good;
  logic                  rx_bad;

  modport slave (
    input  req_valid, req_type, req_addr, req_data,
    input  tx_done, rx_good, rx_bad,
    output req_ready, rsp_valid, rsp_err,
    output tx_type, tx_tag, tx_addr, tx_data, tx_start,
    output rx_type, rx_tag, rx_data
  );

  modport master (
    output req_valid, req_type, req_addr, req_data,
    output tx_done, rx_good, rx_bad,
    input  req_ready, rsp_valid, rsp_err,
    input  tx_type, tx_tag, tx_addr, tx_data, tx_start,
    input  rx_type, rx_tag, rx_data
  );

endinterface

// File: rtl/pio_tx_arbiter_rr_arbiter.sv
// Round-robin requester selection: combinational first-set search starting
// at rr_ptr (wrapping), plus the pointer register that moves past the
// granted index whenever a grant is taken.
module pio_tx_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               user_clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic               grant_any,
  output logic [REQ_W-1:0]   grant_idx
);

  logic [REQ_W-1:0] rr_ptr;

  function automatic logic [REQ_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return REQ_W'(s);
  endfunction

  // Scan offsets from farthest to nearest so the requester closest to rr_ptr wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[wrap_idx(int'(rr_ptr), i)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_idx(int'(rr_ptr), i);
      end
    end
  end

  // Move the pointer one past the index that was just granted.
  always_ff @(posedge user_clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (reset) rr_ptr <= '0;
    else if (advance) rr_ptr <= wrap_idx(int'(grant_idx), 1);
  end

endmodule

// File: rtl/pio_tx_arbiter.sv
// PIO TX arbiter: shares one TLP generator / completion checker pair among
// NUM_REQ requesters. One TLP in flight, round-robin grant, 8-bit tag per
// issued TLP, completion timeout, one-hot done/error status per requester.
module pio_tx_arbiter
  import pio_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int REQ_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int CPL_TIMEOUT = 1024
) (
  input  logic               user_clk,
  input  logic               reset,
  input  logic               user_lnk_up,
  pio_tx_arbiter_if.slave    bus
);

  localparam int              CNT_W    = $clog2(CPL_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPL_TIMEOUT - 1);

  arb_state_t       state, state_nxt;
  logic             err_q, err_nxt;
  logic             advance, issue, cpl_enter;
  logic             grant_any;
  logic [REQ_W-1:0] grant_idx;
  logic [REQ_W-1:0] idx_q;
  logic [2:0]       type_q;
  logic [63:0]      addr_q;
  logic [31:0]      data_q;
  logic [CNT_W-1:0] cnt_q;

  pio_tx_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_rr (
    .user_clk  (user_clk),
    .reset     (reset),
    .req       (bus.req_valid),
    .advance   (advance),
    .grant_any (grant_any),
    .grant_idx (grant_idx)
  );

  // Next-state decode; err_nxt is set on every transition into ST_RESP.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    advance   = 1'b0;
    issue     = 1'b0;
    cpl_enter = 1'b0;
    case (state)
      ST_IDLE: begin
        if (user_lnk_up && grant_any) begin
          advance   = 1'b1;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Undefined codes and a dead link skip the generator entirely.
        if (!user_lnk_up || !tx_type_defined(type_q)) begin
          state_nxt = ST_RESP;
          err_nxt   = 1'b1;
        end else begin
          issue     = 1'b1;
          state_nxt = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        if (!user_lnk_up) begin
          state_nxt = ST_RESP;
          err_nxt   = 1'b1;
        end else if (bus.tx_done) begin
          if (tx_type_posted(type_q)) begin
            state_nxt = ST_RESP;
            err_nxt   = 1'b0;
          end else begin
            cpl_enter = 1'b1;
            state_nxt = ST_CPL_WAIT;
          end
        end
      end
      ST_CPL_WAIT: begin
        // rx_bad outranks rx_good when both arrive together.
        if (!user_lnk_up || bus.rx_bad) begin
          state_nxt = ST_RESP;
          err_nxt   = 1'b1;
        end else if (bus.rx_good) begin
          state_nxt = ST_RESP;
          err_nxt   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = ST_RESP;
          err_nxt   = 1'b1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and pending-error registers.
  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
    end
  end

  // Capture the granted requester's command when the grant is taken.
  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      type_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (advance) begin
      idx_q  <= grant_idx;
      type_q <= bus.req_type[3*grant_idx +: 3];
      addr_q <= bus.req_addr[64*grant_idx +: 64];
      data_q <= bus.req_data[32*grant_idx +: 32];
    end
  end

  // Completion timeout counter, restarted as the TLP enters ST_CPL_WAIT.
  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else if (cpl_enter) cnt_q <= '0;
    else if (state == ST_CPL_WAIT) cnt_q <= cnt_q + 1'b1;
  end

  // Registered outputs: pulses clear every cycle, tx_*/rx_* hold until the next issue.
  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_err   <= 1'b0;
      bus.tx_type   <= '0;
      bus.tx_tag    <= '0;
      bus.tx_addr   <= '0;
      bus.tx_data   <= '0;
      bus.tx_start  <= 1'b0;
      bus.rx_type   <= 1'b0;
      bus.rx_tag    <= '0;
      bus.rx_data   <= '0;
    end else begin
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_err   <= 1'b0;
      bus.tx_start  <= 1'b0;
      if (advance) bus.req_ready <= NUM_REQ'(1) << grant_idx;
      if (issue) begin
        bus.tx_type  <= type_q;
        bus.tx_addr  <= addr_q;
        bus.tx_data  <= data_q;
        bus.tx_tag   <= bus.tx_tag + 8'd1;
        bus.rx_tag   <= bus.tx_tag + 8'd1;
        bus.rx_type  <= rx_type_for(type_q);
        bus.rx_data  <= data_q;
        bus.tx_start <= 1'b1;
      end
      if (state == ST_RESP) begin
        bus.rsp_valid <= NUM_REQ'(1) << idx_q;
        bus.rsp_err   <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_pio_tx_arbiter.sv
// Directed testbench for pio_tx_arbiter (NUM_REQ=2, CPL_TIMEOUT=16):
// table of single transactions, then hand-written sequences for
// round-robin alternation, completion timeout, link drop, asynchronous
// reset and tag wrap-around.
module tb_pio_tx_arbiter;
  import pio_tx_arbiter_pkg::*;

  localparam logic [2:0] TX_TYPE_UNDEF = 3'b110;

  typedef enum int {C_POSTED, C_GOOD, C_BAD, C_BOTH, C_UNDEF} cpl_t;

  typedef struct {
    int          req;
    logic [2:0]  ty;
    logic [63:0] addr;
    logic [31:0] data;
    cpl_t        cpl;
    logic [1:0]  exp_ready;
    logic [7:0]  exp_tag;
    logic        exp_rx_type;
    logic [1:0]  exp_rsp;
    logic        exp_err;
  } vec_t;

  logic user_clk    = 1'b0;
  logic reset       = 1'b1;
  logic user_lnk_up = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[8];

  pio_tx_arbiter_if #(.NUM_REQ(2)) bus ();

  pio_tx_arbiter #(
    .NUM_REQ     (2),
    .CPL_TIMEOUT (16)
  ) dut (
    .user_clk    (user_clk),
    .reset       (reset),
    .user_lnk_up (user_lnk_up),
    .bus         (bus)
  );

  always #5 user_clk = ~user_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one transaction starting at a negedge in ST_IDLE; ends at the
  // negedge where rsp_valid is visible.
  task automatic run_vec(input vec_t v);
    int r;
    r = v.req;
    bus.req_type[3*r +: 3]   = v.ty;
    bus.req_addr[64*r +: 64] = v.addr;
    bus.req_data[32*r +: 32] = v.data;
    bus.req_valid            = 2'b01 << r;
    @(negedge user_clk);
    check("req_ready", bus.req_ready, v.exp_ready);
    check("tx_start before grant", bus.tx_start, 0);
    bus.req_valid = '0;
    @(negedge user_clk);
    if (v.cpl == C_UNDEF) begin
      check("tx_start undefined type", bus.tx_start, 0);
      check("tx_tag undefined type", bus.tx_tag, v.exp_tag);
    end else begin
      check("tx_start", bus.tx_start, 1);
      check("tx_tag", bus.tx_tag, v.exp_tag);
      check("rx_tag", bus.rx_tag, v.exp_tag);
      check("tx_type", bus.tx_type, v.ty);
      check("tx_addr", bus.tx_addr, v.addr);
      check("tx_data", bus.tx_data, v.data);
      check("rx_data", bus.rx_data, v.data);
      check("rx_type", bus.rx_type, v.exp_rx_type);
      bus.tx_done = 1'b1;
      @(negedge user_clk);
      bus.tx_done = 1'b0;
      check("tx_start one cycle", bus.tx_start, 0);
      if (v.cpl != C_POSTED) begin
        bus.rx_good = (v.cpl == C_GOOD) || (v.cpl == C_BOTH);
        bus.rx_bad  = (v.cpl == C_BAD)  || (v.cpl == C_BOTH);
        @(negedge user_clk);
        bus.rx_good = 1'b0;
        bus.rx_bad  = 1'b0;
      end
    end
    @(negedge user_clk);
    check("rsp_valid", bus.rsp_valid, v.exp_rsp);
    check("rsp_err", bus.rsp_err, v.exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, finished=0 required=1");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t w;
    int   k;
    logic [63:0] a0, a1;

    vecs[0] = '{0, TX_TYPE_MEMWR32, 64'h0000_0000_FFFF_0010, 32'h1234_5678, C_POSTED, 2'b01, 8'd1, 1'b0, 2'b01, 1'b0};
    vecs[1] = '{1, TX_TYPE_MEMRD32, 64'h0000_0000_0000_0400, 32'h1234_5678, C_GOOD,   2'b10, 8'd2, 1'b1, 2'b10, 1'b0};
    vecs[2] = '{1, TX_TYPE_MEMRD32, 64'h0000_0000_0000_0404, 32'hCAFE_F00D, C_BAD,    2'b10, 8'd3, 1'b1, 2'b10, 1'b1};
    vecs[3] = '{0, TX_TYPE_IOWR,    64'h0000_0000_0000_1000, 32'hA5A5_5A5A, C_GOOD,   2'b01, 8'd4, 1'b0, 2'b01, 1'b0};
    vecs[4] = '{1, TX_TYPE_MEMRD64, 64'h8000_0001_0000_0040, 32'h0BAD_BEEF, C_BOTH,   2'b10, 8'd5, 1'b1, 2'b10, 1'b1};
    vecs[5] = '{0, TX_TYPE_IORD,    64'h0000_0000_0000_2000, 32'h0000_00FF, C_GOOD,   2'b01, 8'd6, 1'b1, 2'b01, 1'b0};
    vecs[6] = '{1, TX_TYPE_MEMWR64, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF, C_POSTED, 2'b10, 8'd7, 1'b0, 2'b10, 1'b0};
    vecs[7] = '{1, TX_TYPE_UNDEF,   64'h0000_0000_0000_DEAD, 32'h0000_0000, C_UNDEF,  2'b10, 8'd7, 1'b0, 2'b10, 1'b1};

    bus.req_valid = '0;
    bus.req_type  = {3'b111, 3'b111};
    bus.req_addr  = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    bus.req_data  = {32'h9999_AAAA, 32'hBBBB_CCCC};
    bus.tx_done   = 1'b0;
    bus.rx_good   = 1'b0;
    bus.rx_bad    = 1'b0;

    // Reset state
    #1;
    check("reset pulses", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.tx_start}, 0);
    check("reset tx_tag", bus.tx_tag, 0);
    check("reset tx_addr", bus.tx_addr, 0);
    repeat (2) @(negedge user_clk);
    reset = 1'b0;

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Both requesters valid continuously: grants alternate 0,1,0,1
    a0 = 64'h0000_0000_0000_A000;
    a1 = 64'h0000_0000_0000_B000;
    bus.req_type  = {TX_TYPE_MEMWR32, TX_TYPE_MEMWR32};
    bus.req_addr  = {a1, a0};
    bus.req_data  = {32'h1111_1111, 32'h0000_0000};
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge user_clk);
      check("rr req_ready", bus.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge user_clk);
      check("rr tx_start", bus.tx_start, 1);
      check("rr tx_tag", bus.tx_tag, 8 + i);
      check("rr tx_addr", bus.tx_addr, (i % 2 == 0) ? a0 : a1);
      bus.tx_done = 1'b1;
      @(negedge user_clk);
      bus.tx_done = 1'b0;
      @(negedge user_clk);
      check("rr rsp_valid", bus.rsp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    bus.req_valid = '0;

    // Completion timeout: no rx_good/rx_bad after tx_done
    bus.req_type[2:0] = TX_TYPE_MEMRD32;
    bus.req_valid     = 2'b01;
    @(negedge user_clk);
    check("timeout req_ready", bus.req_ready, 2'b01);
    bus.req_valid = '0;
    @(negedge user_clk);
    check("timeout tx_tag", bus.tx_tag, 12);
    bus.tx_done = 1'b1;
    @(negedge user_clk);
    bus.tx_done = 1'b0;
    k = 0;
    while (k < 40) begin
      @(negedge user_clk);
      k++;
      if (bus.rsp_valid != 0) break;
    end
    check("timeout latency", k, 17);
    check("timeout rsp_valid", bus.rsp_valid, 2'b01);
    check("timeout rsp_err", bus.rsp_err, 1);
    w = '{1, TX_TYPE_MEMWR32, 64'h0000_0000_0000_3000, 32'h0000_3333, C_POSTED, 2'b10, 8'd13, 1'b0, 2'b10, 1'b0};
    run_vec(w);

    // Link drop while waiting for a completion
    bus.req_type[5:3] = TX_TYPE_MEMRD32;
    bus.req_valid     = 2'b10;
    @(negedge user_clk);
    bus.req_valid = '0;
    @(negedge user_clk);
    check("lnk tx_tag", bus.tx_tag, 14);
    bus.tx_done = 1'b1;
    @(negedge user_clk);
    bus.tx_done = 1'b0;
    user_lnk_up = 1'b0;
    @(negedge user_clk);
    @(negedge user_clk);
    check("lnk rsp_valid", bus.rsp_valid, 2'b10);
    check("lnk rsp_err", bus.rsp_err, 1);
    bus.req_type[2:0] = TX_TYPE_MEMWR32;
    bus.req_valid     = 2'b01;
    for (int i = 0; i < 6; i++) begin
      @(negedge user_clk);
      check("lnk down no grant", {bus.req_ready, bus.tx_start}, 0);
    end
    user_lnk_up = 1'b1;
    w = '{0, TX_TYPE_MEMWR32, 64'h0000_0000_0000_4000, 32'h0000_4444, C_POSTED, 2'b01, 8'd15, 1'b0, 2'b01, 1'b0};
    run_vec(w);

    // Asynchronous reset mid-transaction
    bus.req_type[5:3] = TX_TYPE_MEMWR32;
    bus.req_valid     = 2'b10;
    @(negedge user_clk);
    bus.req_valid = '0;
    @(negedge user_clk);
    check("pre-reset tx_start", bus.tx_start, 1);
    check("pre-reset tx_tag", bus.tx_tag, 16);
    #2 reset = 1'b1;
    #1;
    check("async reset pulses", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.tx_start}, 0);
    check("async reset tags", {bus.tx_type, bus.tx_tag, bus.rx_type, bus.rx_tag}, 0);
    check("async reset tx_addr", bus.tx_addr, 0);
    check("async reset data", {bus.tx_data, bus.rx_data}, 0);
    @(negedge user_clk);
    reset = 1'b0;

    // 256 sequential writes: tag runs 1..255 then wraps to 0
    for (int i = 1; i <= 256; i++) begin
      w = '{i % 2, TX_TYPE_MEMWR32, 64'(i), 32'(~i), C_POSTED,
            (i % 2 == 1) ? 2'b10 : 2'b01, 8'(i), 1'b0,
            (i % 2 == 1) ? 2'b10 : 2'b01, 1'b0};
      run_vec(w);
    end
    check("tag after wrap", bus.tx_tag, 0);

    // rx_good and rx_bad together after the wrap
    w = '{0, TX_TYPE_MEMRD32, 64'h0000_0000_0000_5000, 32'h5555_5555, C_BOTH, 2'b01, 8'd1, 1'b1, 2'b01, 1'b1};
    run_vec(w);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
